// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Bridges the EX/MEM pipeline register and a word-oriented data memory.
// Takes one load/store request at a time. Downstream it issues only
// word-aligned, full-word accesses: sub-word loads are extracted and
// extended here, and SB/SH become read-modify-write sequences. Misaligned or
// illegal requests are answered with resp_err and never touch memory.
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   req_valid/ready : request handshake (ready only while IDLE)
//   req_read/write  : load / store selector
//   req_funct3      : RV32I load/store width/sign encoding
//   req_addr        : byte address
//   req_wdata       : store data (rs2)
//   resp_valid      : one-cycle completion pulse
//   resp_rdata      : extended load data (0 for stores and errors)
//   resp_err        : misaligned / illegal request, valid with resp_valid
//   mem_addr        : word-aligned memory address
//   mem_wdata       : full word to write
//   mem_read        : read strobe, data returns the following cycle
//   mem_write       : write strobe
//   mem_funct3      : always word access
//   mem_rdata       : memory read data
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_read,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [2:0]               mem_funct3,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  // How an incoming request will be serviced.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ERR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_SW   = 3'd3,
    OP_RMW  = 3'd4
  } op_t;

  // Decode a request into its service path, including alignment checks.
  function automatic op_t classify(input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [1:0] lane);
    op_t op;
    op = OP_ERR;
    if (rd && wr) begin
      op = OP_ERR;
    end else if (rd) begin
      case (f3)
        3'b000, 3'b100: op = OP_LOAD;
        3'b001, 3'b101: op = lane[0] ? OP_ERR : OP_LOAD;
        3'b010:         op = (lane != 2'b00) ? OP_ERR : OP_LOAD;
        default:        op = OP_ERR;
      endcase
    end else if (wr) begin
      case (f3)
        3'b000:  op = OP_RMW;
        3'b001:  op = lane[0] ? OP_ERR : OP_RMW;
        3'b010:  op = (lane != 2'b00) ? OP_ERR : OP_SW;
        default: op = OP_ERR;
      endcase
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

  // Pick the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] word,
                                                        input logic [2:0] f3,
                                                        input logic [1:0] lane);
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    if (lane[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (f3)
      3'b000:  res = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b100:  res = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b001:  res = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b101:  res = {{(DATA_WIDTH-16){1'b0}}, h};
      3'b010:  res = word;
      default: res = {DATA_WIDTH{1'b0}};
    endcase
    return res;
  endfunction

  // Replace only the addressed byte/half of the old word with store data.
  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] old_word,
                                                        input logic [DATA_WIDTH-1:0] wd,
                                                        input logic [2:0] f3,
                                                        input logic [1:0] lane);
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    case (f3)
      3'b000: begin
        case (lane)
          2'd0:    res[7:0]   = wd[7:0];
          2'd1:    res[15:8]  = wd[7:0];
          2'd2:    res[23:16] = wd[7:0];
          2'd3:    res[31:24] = wd[7:0];
          default: res = old_word;
        endcase
      end
      3'b001: begin
        if (lane[1]) begin
          res[31:16] = wd[15:0];
        end else begin
          res[15:0] = wd[15:0];
        end
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  state_t                  state_r;
  state_t                  next_state_s;
  op_t                     req_op_s;
  logic                    accept_s;

  logic                    read_r;
  logic                    write_r;
  logic [2:0]              funct3_r;
  logic [1:0]              lane_r;
  logic [DATA_WIDTH-1:0]   wdata_r;

  logic                    req_ready_r;
  logic                    resp_valid_r;
  logic [DATA_WIDTH-1:0]   resp_rdata_r;
  logic                    resp_err_r;
  logic [ADDRESS_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0]   mem_wdata_r;
  logic                    mem_read_r;
  logic                    mem_write_r;

  assign req_op_s = classify(req_read, req_write, req_funct3, req_addr[1:0]);
  assign accept_s = (state_r == IDLE) && req_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          case (req_op_s)
            OP_LOAD, OP_RMW: next_state_s = READ;
            OP_SW:           next_state_s = WRITE;
            default:         next_state_s = RESP;
          endcase
        end else begin
          next_state_s = IDLE;
        end
      end
      READ:  next_state_s = LATCH;
      LATCH: begin
        if (write_r) begin
          next_state_s = WRITE;
        end else begin
          next_state_s = RESP;
        end
      end
      WRITE:   next_state_s = RESP;
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request holding registers, loaded only on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_r   <= 1'b0;
      write_r  <= 1'b0;
      funct3_r <= 3'b000;
      lane_r   <= 2'b00;
      wdata_r  <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      read_r   <= req_read;
      write_r  <= req_write;
      funct3_r <= req_funct3;
      lane_r   <= req_addr[1:0];
      wdata_r  <= req_wdata;
    end else begin
      read_r   <= read_r;
      write_r  <= write_r;
      funct3_r <= funct3_r;
      lane_r   <= lane_r;
      wdata_r  <= wdata_r;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= {DATA_WIDTH{1'b0}};
      resp_err_r   <= 1'b0;
      mem_addr_r   <= {ADDRESS_WIDTH{1'b0}};
      mem_wdata_r  <= {DATA_WIDTH{1'b0}};
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
    end else begin
      req_ready_r  <= (next_state_s == IDLE);
      resp_valid_r <= (next_state_s == RESP);
      mem_read_r   <= (next_state_s == READ);
      mem_write_r  <= (next_state_s == WRITE);

      // Word address is held for the whole operation and parked at 0 in IDLE.
      if (next_state_s == IDLE) begin
        mem_addr_r <= {ADDRESS_WIDTH{1'b0}};
      end else if (accept_s) begin
        mem_addr_r <= {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
      end else begin
        mem_addr_r <= mem_addr_r;
      end

      // SW writes rs2 directly; SB/SH merge into the word read back in LATCH.
      if (next_state_s == IDLE) begin
        mem_wdata_r <= {DATA_WIDTH{1'b0}};
      end else if (accept_s && (req_op_s == OP_SW)) begin
        mem_wdata_r <= req_wdata;
      end else if ((state_r == LATCH) && write_r) begin
        mem_wdata_r <= store_merge(mem_rdata, wdata_r, funct3_r, lane_r);
      end else begin
        mem_wdata_r <= mem_wdata_r;
      end

      // Load data is captured as LATCH hands over to RESP.
      if ((state_r == LATCH) && read_r) begin
        resp_rdata_r <= load_extend(mem_rdata, funct3_r, lane_r);
      end else if (state_r == RESP) begin
        resp_rdata_r <= {DATA_WIDTH{1'b0}};
      end else begin
        resp_rdata_r <= resp_rdata_r;
      end

      // Errors go straight to RESP, so the flag set on accept lines up with it.
      if (accept_s) begin
        resp_err_r <= (req_op_s == OP_ERR);
      end else if (state_r == RESP) begin
        resp_err_r <= 1'b0;
      end else begin
        resp_err_r <= resp_err_r;
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_read   = mem_read_r;
  assign mem_write  = mem_write_r;
  assign mem_funct3 = 3'b010;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed self-checking bench for load_store_unit. A word memory model
// answers mem_read one cycle later and commits mem_write on the falling
// edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [8:0]  req_addr = 9'h000;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem [0:127];
  logic        bd_we = 1'b0;
  logic [6:0]  bd_addr = 7'd0;
  logic [31:0] bd_data = 32'h0;

  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  logic [8:0]  last_wr_addr = 9'h000;
  logic [31:0] last_wr_data = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  logic [2:0]  q_f3   [3];
  logic [8:0]  q_addr [3];
  logic [31:0] q_exp  [3];

  load_store_unit #(.ADDRESS_WIDTH(9), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory read port: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem[mem_addr[8:2]];
  end

  // Memory write port (falling edge) plus backdoor preload.
  always @(negedge clk) begin
    if (mem_write) mem[mem_addr[8:2]] <= mem_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  // Strobe monitor.
  always @(negedge clk) begin
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_wdata;
    end
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bd_write(input logic [6:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_ready"},  32'(req_ready),  32'd1);
    check_value({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
    check_value({tag, "_rdata"},  resp_rdata,      32'd0);
    check_value({tag, "_err"},    32'(resp_err),   32'd0);
    check_value({tag, "_mrd"},    32'(mem_read),   32'd0);
    check_value({tag, "_mwr"},    32'(mem_write),  32'd0);
    check_value({tag, "_maddr"},  32'(mem_addr),   32'd0);
    check_value({tag, "_mwdata"}, mem_wdata,       32'd0);
  endtask

  // Issue one request and check latency, ready-low cycles, result and strobes.
  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_rd, input int exp_wr);
    int lat, ready_low, rd0, wr0;
    logic [31:0] rdata;
    logic err, done;
    @(negedge clk);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    lat = 0; ready_low = 0; rdata = 32'h0; err = 1'b0; done = 1'b0;
    for (int k = 1; k <= 12 && !done; k++) begin
      @(negedge clk);
      if (!req_ready) ready_low++;
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; err = resp_err; done = 1'b1;
      end
    end
    check_value({tag, "_seen"},  32'(done),   32'd1);
    check_value({tag, "_lat"},   lat,         exp_lat);
    check_value({tag, "_busy"},  ready_low,   exp_lat);
    check_value({tag, "_rdata"}, rdata,       exp_rdata);
    check_value({tag, "_err"},   32'(err),    32'(exp_err));
    check_value({tag, "_nrd"},   rd_cnt - rd0, exp_rd);
    check_value({tag, "_nwr"},   wr_cnt - wr0, exp_wr);
  endtask

  initial begin
    int pulses, acc_idx, last_pulse, wr0;

    q_f3[0] = 3'b010; q_addr[0] = 9'h010; q_exp[0] = 32'h8080_7F01;
    q_f3[1] = 3'b000; q_addr[1] = 9'h011; q_exp[1] = 32'h0000_007F;
    q_f3[2] = 3'b001; q_addr[2] = 9'h022; q_exp[2] = 32'h0000_1234;

    // Preload memory while in reset.
    bd_write(7'd4,  32'h8080_7F01);
    bd_write(7'd12, 32'hCAFE_F00D);
    bd_write(7'd0,  32'h3333_4444);
    bd_write(7'd1,  32'h1111_2222);
    bd_write(7'd8,  32'h0000_0000);
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    check_value("mem_funct3", 32'(mem_funct3), 32'd2);
    reset = 1'b0;

    // Sub-word loads from word 0x010 = 0x8080_7F01.
    run_op("lb13",  1'b1, 1'b0, 3'b000, 9'h013, 32'h0, 3, 32'hFFFF_FF80, 1'b0, 1, 0);
    run_op("lbu13", 1'b1, 1'b0, 3'b100, 9'h013, 32'h0, 3, 32'h0000_0080, 1'b0, 1, 0);
    run_op("lh12",  1'b1, 1'b0, 3'b001, 9'h012, 32'h0, 3, 32'hFFFF_8080, 1'b0, 1, 0);
    run_op("lhu10", 1'b1, 1'b0, 3'b101, 9'h010, 32'h0, 3, 32'h0000_7F01, 1'b0, 1, 0);

    // Full-word store then readback.
    run_op("sw20", 1'b0, 1'b1, 3'b010, 9'h020, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 0, 1);
    check_value("sw20_waddr", 32'(last_wr_addr), 32'h020);
    check_value("sw20_wdata", last_wr_data, 32'hDEAD_BEEF);
    run_op("lw20", 1'b1, 1'b0, 3'b010, 9'h020, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1, 0);

    // Read-modify-write stores.
    run_op("sb21", 1'b0, 1'b1, 3'b000, 9'h021, 32'h0000_0055, 4, 32'h0, 1'b0, 1, 1);
    check_value("sb21_mem", mem[8], 32'hDEAD_55EF);
    run_op("sh22", 1'b0, 1'b1, 3'b001, 9'h022, 32'h0000_1234, 4, 32'h0, 1'b0, 1, 1);
    check_value("sh22_mem", mem[8], 32'h1234_55EF);
    check_value("sh22_waddr", 32'(last_wr_addr), 32'h020);

    // Error cases and a no-op request.
    run_op("lw06",  1'b1, 1'b0, 3'b010, 9'h006, 32'h0,         1, 32'h0, 1'b1, 0, 0);
    run_op("sh03",  1'b0, 1'b1, 3'b001, 9'h003, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, 0, 0);
    run_op("ld011", 1'b1, 1'b0, 3'b011, 9'h000, 32'h0,         1, 32'h0, 1'b1, 0, 0);
    run_op("rdwr",  1'b1, 1'b1, 3'b010, 9'h000, 32'h0,         1, 32'h0, 1'b1, 0, 0);
    run_op("none",  1'b0, 1'b0, 3'b010, 9'h000, 32'h0,         1, 32'h0, 1'b0, 0, 0);
    check_value("err_mem0", mem[0], 32'h3333_4444);
    check_value("err_mem1", mem[1], 32'h1111_2222);

    // Reset during LATCH of SB 0x030.
    @(negedge clk);
    wr0 = wr_cnt;
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
    req_funct3 = 3'b000; req_addr = 9'h030; req_wdata = 32'h0000_00AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'b0;
    @(negedge clk);
    check_value("rst_mid_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_value("rst_mid_nwr", wr_cnt - wr0, 32'd0);
    check_value("rst_mid_mem", mem[12], 32'hCAFE_F00D);
    check_value("rst_mid_ready", 32'(req_ready), 32'd1);

    // Three loads queued with req_valid held high.
    pulses = 0; acc_idx = 0; last_pulse = 0;
    for (int c = 0; c < 60 && pulses < 3; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        check_value($sformatf("q%0d_rdata", pulses), resp_rdata, q_exp[pulses]);
        if (pulses > 0) check_value($sformatf("q%0d_gap", pulses), c - last_pulse, 32'd4);
        last_pulse = c;
        pulses++;
      end
      if (req_ready) begin
        if (acc_idx < 3) begin
          req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
          req_funct3 = q_f3[acc_idx]; req_addr = q_addr[acc_idx];
          acc_idx++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0; req_read = 1'b0;
    check_value("q_pulses", pulses, 32'd3);

    check_value("rd_wr_overlap", both_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
